// File: rtl/mat_pkg.sv
// Shared defaults, FSM state encoding and beat-packing slot positions for mat_feed_ctrl.
package mat_pkg;
  localparam int WIDTH_DEF        = 8;
  localparam int NUM_ELEMENTS_DEF = 4;
  localparam int MATRIX_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Element slots within a beat, slot 3 being the most significant
  localparam int SLOT_A0 = 3;
  localparam int SLOT_A1 = 2;
  localparam int SLOT_B0 = 1;
  localparam int SLOT_B1 = 0;
endpackage

// File: rtl/mat_feed_ctrl_if.sv
// Operand/result link between the feed controller (master) and the multiplier array (slave).
interface mat_feed_ctrl_if
  import mat_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF
);
  logic [NUM_ELEMENTS*WIDTH-1:0] rdata;
  logic                          read_en;
  logic                          write_en;
  logic                          write_ready;
  logic [NUM_ELEMENTS*WIDTH-1:0] Res;

  modport master (output rdata, read_en, write_en, input write_ready, Res);
  modport slave  (input rdata, read_en, write_en, output write_ready, Res);
endinterface

// File: rtl/mat_elem_buf.sv
// Square element buffer: synchronous write, two combinational read ports.
// Contents are deliberately not reset so loaded matrices survive a transfer abort.
module mat_elem_buf
  import mat_pkg::*;
#(
  parameter  int WIDTH        = WIDTH_DEF,
  parameter  int MATRIX_WIDTH = MATRIX_WIDTH_DEF,
  localparam int IW           = $clog2(MATRIX_WIDTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    wrow,
  input  logic [IW-1:0]    wcol,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    rrow0,
  input  logic [IW-1:0]    rcol0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [IW-1:0]    rrow1,
  input  logic [IW-1:0]    rcol1,
  output logic [WIDTH-1:0] rdata1
);
  logic [WIDTH-1:0] mem [MATRIX_WIDTH][MATRIX_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wrow][wcol] <= wdata;
  end

  assign rdata0 = mem[rrow0][rcol0];
  assign rdata1 = mem[rrow1][rcol1];
endmodule

// File: rtl/mat_feed_ctrl.sv
// Streams A/B operand pairs to the multiplier, waits PIPE_GAP cycles, then drains MATRIX_WIDTH result
// columns; beats leave unthrottled, results are taken only when write_ready, with a TIMEOUT bound.
module mat_feed_ctrl
  import mat_pkg::*;
#(
  parameter  int WIDTH        = WIDTH_DEF,
  parameter  int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
  parameter  int MATRIX_WIDTH = MATRIX_WIDTH_DEF,
  parameter  int PIPE_GAP     = 4,
  parameter  int TIMEOUT      = 255,
  localparam int IW           = $clog2(MATRIX_WIDTH),
  localparam int DW           = NUM_ELEMENTS*WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [IW-1:0]         load_row,
  input  logic [IW-1:0]         load_col,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  start,
  mat_feed_ctrl_if.master       mif,
  output logic                  res_valid,
  output logic [IW-1:0]         res_col,
  output logic [DW-1:0]         res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int GW = $clog2(PIPE_GAP + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    row_cnt, col_cnt, row_odd;
  logic [GW-1:0]    gap_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             row_wrap, last_beat, gap_end, capture, last_cap, tmo_hit;
  logic             wr_a, wr_b;
  logic [WIDTH-1:0] a0, a1, b0, b1;

  assign wr_a      = (state == IDLE) && load_en && !load_sel;
  assign wr_b      = (state == IDLE) && load_en &&  load_sel;
  assign row_odd   = row_cnt + IW'(1);
  assign row_wrap  = (row_cnt == IW'(MATRIX_WIDTH - 2));
  assign last_beat = row_wrap && (col_cnt == IW'(MATRIX_WIDTH - 1));
  assign gap_end   = (gap_cnt == GW'(PIPE_GAP - 1));
  assign capture   = (state == DRAIN) && mif.write_ready;
  assign last_cap  = capture && (col_cnt == IW'(MATRIX_WIDTH - 1));
  assign tmo_hit   = (state == DRAIN) && !mif.write_ready && (tmo_cnt == TW'(TIMEOUT - 1));

  // Row pair (r, r+1) of column c is read from both matrices in the same cycle
  mat_elem_buf #(.WIDTH(WIDTH), .MATRIX_WIDTH(MATRIX_WIDTH)) u_buf_a (
    .clk(clk), .we(wr_a), .wrow(load_row), .wcol(load_col), .wdata(load_data),
    .rrow0(row_cnt), .rcol0(col_cnt), .rdata0(a0),
    .rrow1(row_odd), .rcol1(col_cnt), .rdata1(a1)
  );

  mat_elem_buf #(.WIDTH(WIDTH), .MATRIX_WIDTH(MATRIX_WIDTH)) u_buf_b (
    .clk(clk), .we(wr_b), .wrow(load_row), .wcol(load_col), .wdata(load_data),
    .rrow0(row_cnt), .rcol0(col_cnt), .rdata0(b0),
    .rrow1(row_odd), .rcol1(col_cnt), .rdata1(b1)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mif.rdata    = '0;
    mif.read_en  = 1'b0;
    mif.write_en = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SEND;
      end
      SEND: begin
        mif.read_en                      = 1'b1;
        mif.rdata[SLOT_A0*WIDTH +: WIDTH] = a0;
        mif.rdata[SLOT_A1*WIDTH +: WIDTH] = a1;
        mif.rdata[SLOT_B0*WIDTH +: WIDTH] = b0;
        mif.rdata[SLOT_B1*WIDTH +: WIDTH] = b1;
        if (last_beat) state_nxt = (PIPE_GAP == 0) ? DRAIN : GAP;
      end
      GAP: begin
        if (gap_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        mif.write_en = 1'b1;
        if (last_cap)     state_nxt = DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // col_cnt indexes the operand column while sending and the result column while draining
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      col_cnt <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        SEND: begin
          if (row_wrap) begin
            row_cnt <= '0;
            col_cnt <= last_beat ? '0 : col_cnt + IW'(1);
          end else begin
            row_cnt <= row_cnt + IW'(2);
          end
        end
        GAP: gap_cnt <= gap_end ? '0 : gap_cnt + GW'(1);
        DRAIN: begin
          if (mif.write_ready) begin
            tmo_cnt <= '0;
            col_cnt <= last_cap ? '0 : col_cnt + IW'(1);
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            col_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_col     <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      res_valid <= capture;
      if (capture) begin
        res_col  <= col_cnt;
        res_data <= mif.Res;
      end
      if ((state == IDLE) && start) timeout_err <= 1'b0;
      else if (tmo_hit)             timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mat_feed_ctrl.sv
// Randomised scoreboard bench for mat_feed_ctrl: a matrix-level model predicts every beat, capture and done.
module tb_mat_feed_ctrl;
  localparam int W   = 8;
  localparam int NE  = 4;
  localparam int MW  = 4;
  localparam int PG  = 4;
  localparam int TMO = 255;
  localparam int NB  = MW*MW/2;

  typedef struct {
    logic [1:0]  col;
    logic [31:0] dat;
  } cap_t;

  logic        clk = 1'b0;
  logic        reset, load_en, load_sel, start;
  logic [1:0]  load_row, load_col;
  logic [7:0]  load_data;
  logic        res_valid, busy, done, timeout_err;
  logic [1:0]  res_col;
  logic [31:0] res_data;

  mat_feed_ctrl_if #(.WIDTH(W), .NUM_ELEMENTS(NE)) mif ();

  mat_feed_ctrl #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(MW), .PIPE_GAP(PG), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .load_row(load_row), .load_col(load_col), .load_data(load_data), .start(start),
    .mif(mif), .res_valid(res_valid), .res_col(res_col), .res_data(res_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  ma [MW][MW];
  logic [7:0]  mb [MW][MW];
  logic [31:0] beat_q [$];
  cap_t        cap_q  [$];
  int          done_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_beat(input int n);
    int r, c;
    r = 2 * (n % (MW/2));
    c = n / (MW/2);
    return {ma[r][c], ma[r+1][c], mb[r][c], mb[r+1][c]};
  endfunction

  task automatic monitor();
    cap_t e;
    forever begin
      @(negedge clk);
      if (mif.read_en) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) chk("beat_data", mif.rdata, beat_q.pop_front());
      end
      if (res_valid) begin
        chk("capture_expected", cap_q.size() != 0, 1);
        if (cap_q.size() != 0) begin
          e = cap_q.pop_front();
          chk("res_col", res_col, e.col);
          chk("res_data", res_data, e.dat);
        end
      end
      if (done) begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
  endtask

  // Called at a negedge; returns one negedge later
  task automatic load_elem(input bit sel, input int r, input int c, input logic [7:0] d);
    load_en = 1'b1; load_sel = sel; load_row = 2'(r); load_col = 2'(c); load_data = d;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Pulses start (optionally with a simultaneous load); returns at the negedge showing beat 0
  task automatic start_xfer(input bit ld, input int r, input int c, input logic [7:0] d, input bit exp_done);
    start = 1'b1;
    if (ld) begin
      load_en = 1'b1; load_sel = 1'b0; load_row = 2'(r); load_col = 2'(c); load_data = d;
      ma[r][c] = d;
    end
    for (int n = 0; n < NB; n++) beat_q.push_back(model_beat(n));
    if (exp_done) done_q.push_back(1);
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
  endtask

  // Measures the beat burst and the idle gap; optionally pokes start/load while busy
  task automatic send_gap(input bit poke);
    int cnt, gap;
    cnt = 0;
    while (mif.read_en && cnt < 100) begin
      if (poke && cnt == 1) begin
        start = 1'b1; load_en = 1'b1; load_sel = 1'b0;
        load_row = 2'd0; load_col = 2'd0; load_data = 8'h55;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0; load_en = 1'b0;
    chk("send_beats", cnt, NB);
    gap = 0;
    while (!mif.write_en && busy && gap < 100) begin
      chk("gap_quiet", {mif.read_en, mif.write_en}, 2'b00);
      gap++;
      @(negedge clk);
    end
    chk("gap_cycles", gap, PG);
  endtask

  task automatic drain(input bit fixed_res);
    int k, cyc;
    k = 0; cyc = 0;
    while (mif.write_en && cyc < 2000) begin
      if (k < MW && $urandom_range(0, 2) != 0) begin
        mif.write_ready = 1'b1;
        mif.Res = fixed_res ? 32'h11223344 + 32'(k) : $urandom;
        cap_q.push_back('{col: 2'(k), dat: mif.Res});
        k++;
      end else begin
        mif.write_ready = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    mif.write_ready = 1'b0;
    chk("captures", k, MW);
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic full_xfer(input bit ld, input logic [7:0] d, input bit poke, input bit fixed_res);
    start_xfer(ld, 0, 0, d, 1'b1);
    send_gap(poke);
    drain(fixed_res);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; load_en = 1'b0; load_sel = 1'b0; start = 1'b0;
    load_row = '0; load_col = '0; load_data = '0;
    mif.write_ready = 1'b0; mif.Res = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_flags", {mif.read_en, mif.write_en, res_valid, busy, done, timeout_err}, 6'b0);
    chk("rst_rdata", mif.rdata, 0);
    chk("rst_res", {res_col, res_data}, 0);
    reset = 1'b0;
    @(negedge clk);

    // A[i][j] = 4i+j, B = identity
    for (int i = 0; i < MW; i++)
      for (int j = 0; j < MW; j++) begin
        load_elem(1'b0, i, j, 8'(4*i + j));
        load_elem(1'b1, i, j, (i == j) ? 8'd1 : 8'd0);
      end
    full_xfer(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain with no write_ready: timeout, no done
    start_xfer(1'b0, 0, 0, 8'h00, 1'b0);
    send_gap(1'b0);
    cnt = 0;
    while (mif.write_en && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_idle", {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    chk("timeout_sticky", timeout_err, 1);

    // Reset during beat 3 aborts immediately; buffers survive
    start_xfer(1'b0, 0, 0, 8'h00, 1'b1);
    chk("timeout_cleared", timeout_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_quiet", {mif.read_en, mif.write_en, busy, done}, 4'b0);
    chk("abort_beats_left", beat_q.size(), NB - 4);
    beat_q.delete(); done_q.delete();
    @(negedge clk);
    chk("abort_stays_idle", {mif.read_en, busy}, 2'b00);
    full_xfer(1'b0, 8'h00, 1'b0, 1'b0);

    // start/load_en while busy are ignored; a repeat transfer shows the buffer unchanged
    full_xfer(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_restart", {mif.read_en, busy}, 2'b00);
    full_xfer(1'b0, 8'h00, 1'b0, 1'b0);

    // Load and start in the same cycle: first beat sees the new A[0][0]
    full_xfer(1'b1, 8'hFF, 1'b0, 1'b0);

    // Random matrices and random ready patterns
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < 6; n++)
        load_elem(1'($urandom_range(0, 1)), $urandom_range(0, MW-1), $urandom_range(0, MW-1), 8'($urandom));
      full_xfer(1'b1, 8'($urandom), 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("cap_q_empty", cap_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mat_feed_ctrl.md
MAT_FEED_CTRL -- requirements
Module: mat_feed_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter NUM_ELEMENTS, default 4, elements per beat.
REQ-003 SHALL have parameter MATRIX_WIDTH, default 4, square matrix dimension (even).
REQ-004 SHALL have parameter PIPE_GAP, default 4, idle cycles between last send beat and drain start.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum drain cycles without write_ready.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port load_en, input, 1, buffer write strobe.
REQ-009 SHALL have port load_sel, input, 1, 0 selects matrix A, 1 selects matrix B.
REQ-010 SHALL have ports load_row and load_col, input, clog2(MATRIX_WIDTH) each, element index.
REQ-011 SHALL have port load_data, input, WIDTH, element value.
REQ-012 SHALL have port start, input, 1, begin transfer pulse.
REQ-013 SHALL have port rdata, output, NUM_ELEMENTS*WIDTH, packed operand beat to multiplier.
REQ-014 SHALL have port read_en, output, 1, rdata valid this cycle.
REQ-015 SHALL have port write_en, output, 1, result request to multiplier.
REQ-016 SHALL have port write_ready, input, 1, Res valid this cycle.
REQ-017 SHALL have port Res, input, NUM_ELEMENTS*WIDTH, packed result column.
REQ-018 SHALL have ports res_valid (1), res_col (clog2(MATRIX_WIDTH)), res_data (NUM_ELEMENTS*WIDTH), output, captured result column.
REQ-019 SHALL have ports busy, done, timeout_err, output, 1 each, status.

Function
REQ-020 SHALL implement states IDLE, SEND, GAP, DRAIN, DONE.
REQ-021 IDLE: load_en writes load_data to A or B[load_row][load_col] next edge; start moves to SEND; busy=0.
REQ-022 load_en outside IDLE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-023 load_en and start in the same IDLE cycle: write SHALL land, first SEND beat SHALL use the new value.
REQ-024 SEND: MATRIX_WIDTH*MATRIX_WIDTH/2 consecutive beats, read_en=1 each cycle, no gaps.
REQ-025 Beat n SHALL carry {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}, A[r][c] in MSBs, r=2*(n mod (MATRIX_WIDTH/2)), c=n/(MATRIX_WIDTH/2).
REQ-026 After last beat SHALL enter GAP for exactly PIPE_GAP cycles, read_en=0, write_en=0.
REQ-027 DRAIN: write_en=1 held; each cycle with write_ready=1 SHALL register Res into res_data, pulse res_valid one cycle later, res_col=capture index 0..MATRIX_WIDTH-1.
REQ-028 After MATRIX_WIDTH captures SHALL drop write_en the next cycle and enter DONE.
REQ-029 DRAIN cycle counter SHALL reset on each capture; reaching TIMEOUT without write_ready SHALL set timeout_err (sticky until next start), go IDLE, no done.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE.
REQ-031 busy SHALL be 1 in SEND, GAP, DRAIN, DONE.
REQ-032 Beat and column counters SHALL wrap to 0 on state exit; no counter overflow permitted.

Reset
REQ-033 reset SHALL force IDLE; read_en, write_en, res_valid, busy, done, timeout_err, rdata, res_data, res_col all 0.
REQ-034 reset mid-transfer SHALL abort next edge with no further beats or captures.
REQ-035 A/B buffer contents SHALL NOT be cleared by reset.

Structure
REQ-036 Package mat_pkg SHALL hold WIDTH/NUM_ELEMENTS/MATRIX_WIDTH defaults, state enum, beat-packing index constants.
REQ-037 Sub-module mat_elem_buf SHALL hold one MATRIX_WIDTH x MATRIX_WIDTH buffer (sync write, two combinational read ports), instantiated for A and B.

Verification
REQ-038 A[i][j]=4i+j, B=identity, start -> 8 beats, beat0=0x00040100, beat1=0x080C0000, read_en high 8 consecutive cycles.
REQ-039 After beats -> GAP exactly 4 cycles, then write_en=1; write_ready pulses with Res=0x11223344.. -> res_valid x4, res_col 0..3, done one cycle.
REQ-040 write_ready held 0 in DRAIN -> timeout_err=1 after 255 cycles, IDLE, done never asserted.
REQ-041 reset asserted at beat 3 -> read_en=0 next cycle, busy=0; restart resends from beat0 with unchanged buffers.
REQ-042 start while busy and load_en while busy -> no restart, buffer unchanged; load_en+start same cycle with A[0][0]=0xFF -> beat0 MSB byte=0xFF.
